udp_pkt_rx: RTL and testbench

Byte-wide GMII-style receiver for the same IPv4/UDP/Ethernet framing our packet generator emits. It strips the preamble and SFD, filters on destination MAC, IP and UDP port, and verifies the IPv4 header checksum and the Ethernet FCS. The UDP payload is streamed out one byte per clock, and a frame-done pulse with a pass/fail verdict follows the FCS. It sits between the PHY RX pins and the application data sink.

---
 rtl/udp_pkt_rx.sv | 136 +++++++++++++
 tb/tb_udp_pkt_rx.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/udp_pkt_rx.sv
// udp_pkt_rx: GMII byte receiver that filters IPv4/UDP frames addressed to us,
// streams the UDP payload and reports an FCS/length/error verdict per frame.
module udp_pkt_rx #(
    parameter logic [47:0] MY_MAC  = 48'h0C54A5312485,
    parameter logic [31:0] MY_IP   = 32'h0A000002,
    parameter logic [15:0] MY_PORT = 16'hC360
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  i_data,
    input  logic        i_dv,
    input  logic        i_er,
    output logic [7:0]  o_data,
    output logic        o_valid,
    output logic        o_sop,
    output logic        o_last,
    output logic        o_done,
    output logic        o_ok,
    output logic [15:0] o_len,
    output logic [31:0] o_src_ip,
    output logic [15:0] o_src_port,
    output logic [15:0] o_good_cnt,
    output logic [15:0] o_bad_cnt,
    output logic [15:0] o_drop_cnt
);
    typedef enum logic [3:0] {
        IDLE, PRE, DST_MAC, SRC_MAC, ETYPE, IP_HDR, UDP_HDR, PAYLOAD, TRAIL, DROP_WAIT
    } state_t;
    state_t state, state_n;
    logic [15:0] cnt, csum, csum_n, word;
    logic [16:0] s17;
    logic [39:0] sh;
    logic [31:0] crc, crc_n;
    logic err, in_frm, hdr_tail, rej, done, drop, ok, pay_v;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) r = (r[0] ^ d[i]) ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
        return r;
    endfunction

    always_comb begin
        word     = {sh[7:0], i_data};
        s17      = {1'b0, csum} + {1'b0, word};
        csum_n   = s17[15:0] + {15'd0, s17[16]};
        crc_n    = crc_byte(crc, i_data);
        in_frm   = state inside {DST_MAC, SRC_MAC, ETYPE, IP_HDR, UDP_HDR, PAYLOAD, TRAIL};
        hdr_tail = state inside {IP_HDR, UDP_HDR};
        pay_v    = i_dv && state == PAYLOAD;
        ok       = crc == 32'hDEBB20E3 && state == TRAIL && cnt >= 16'd4 && !err;
        state_n  = state;
        rej      = 1'b0;
        done     = 1'b0;
        drop     = 1'b0;
        if (!i_dv) begin
            state_n = IDLE;
            done    = in_frm && !hdr_tail;
            drop    = hdr_tail;
        end else begin
            case (state)
                IDLE:    state_n = (i_data == 8'h55) ? PRE : DROP_WAIT;
                PRE:     state_n = (i_data == 8'hD5) ? DST_MAC :
                                   (i_data == 8'h55 && cnt != 16'd6) ? PRE : DROP_WAIT;
                DST_MAC: if (cnt == 16'd5) begin
                    rej     = {sh, i_data} != MY_MAC && {sh, i_data} != '1;
                    state_n = SRC_MAC;
                end
                SRC_MAC: if (cnt == 16'd5) state_n = ETYPE;
                ETYPE:   if (cnt == 16'd1) begin
                    rej     = word != 16'h0800;
                    state_n = IP_HDR;
                end
                IP_HDR: begin
                    rej = (cnt == 16'd0 && i_data != 8'h45) ||
                          (cnt == 16'd7 && word[13:0] != 14'd0) ||
                          (cnt == 16'd9 && i_data != 8'd17) ||
                          (cnt == 16'd19 && ({sh[23:0], i_data} != MY_IP || csum_n != 16'hFFFF));
                    if (cnt == 16'd19) state_n = UDP_HDR;
                end
                UDP_HDR: begin
                    rej = (cnt == 16'd3 && word != MY_PORT) || (cnt == 16'd5 && word < 16'd8);
                    if (cnt == 16'd7) state_n = (o_len == 16'd0) ? TRAIL : PAYLOAD;
                end
                PAYLOAD: if (cnt == o_len - 16'd1) state_n = TRAIL;
                default: ;
            endcase
            if (rej) begin
                state_n = DROP_WAIT;
                drop    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 16'd0;
            sh         <= 40'd0;
            csum       <= 16'd0;
            crc        <= 32'd0;
            err        <= 1'b0;
            o_data     <= 8'd0;
            o_valid    <= 1'b0;
            o_sop      <= 1'b0;
            o_last     <= 1'b0;
            o_done     <= 1'b0;
            o_ok       <= 1'b0;
            o_len      <= 16'd0;
            o_src_ip   <= 32'd0;
            o_src_port <= 16'd0;
            o_good_cnt <= 16'd0;
            o_bad_cnt  <= 16'd0;
            o_drop_cnt <= 16'd0;
        end else begin
            state   <= state_n;
            cnt     <= (state_n != state) ? 16'd0 : cnt + {15'd0, ~&cnt};
            sh      <= {sh[31:0], i_data};
            csum    <= (state == IP_HDR) ? (cnt[0] ? csum_n : csum) : 16'd0;
            crc     <= (state == PRE) ? '1 : (in_frm && i_dv) ? crc_n : crc;
            err     <= (state == PRE) ? 1'b0 : err | (in_frm & i_dv & i_er);
            o_data  <= pay_v ? i_data : 8'd0;
            o_valid <= pay_v;
            o_sop   <= pay_v && cnt == 16'd0;
            o_last  <= pay_v && cnt == o_len - 16'd1;
            o_done  <= done;
            o_ok    <= done && ok;
            if (i_dv && state == IP_HDR && cnt == 16'd15) o_src_ip <= {sh[23:0], i_data};
            if (i_dv && state == UDP_HDR && cnt == 16'd1) o_src_port <= word;
            if (i_dv && state == UDP_HDR && cnt == 16'd5 && word >= 16'd8) o_len <= word - 16'd8;
            o_good_cnt <= o_good_cnt + {15'd0, done && ok};
            o_bad_cnt  <= o_bad_cnt + {15'd0, done && !ok};
            o_drop_cnt <= o_drop_cnt + {15'd0, drop};
        end
    end
endmodule

// File: tb/tb_udp_pkt_rx.sv
// tb_udp_pkt_rx: directed frames through udp_pkt_rx with hand-derived expectations.
module tb_udp_pkt_rx;
    logic        clk = 1'b0, rst_n = 1'b0, i_dv = 1'b0, i_er = 1'b0;
    logic [7:0]  i_data = 8'd0;
    logic [7:0]  o_data;
    logic        o_valid, o_sop, o_last, o_done, o_ok;
    logic [15:0] o_len, o_src_port, o_good_cnt, o_bad_cnt, o_drop_cnt;
    logic [31:0] o_src_ip;

    udp_pkt_rx dut (
        .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_dv(i_dv), .i_er(i_er),
        .o_data(o_data), .o_valid(o_valid), .o_sop(o_sop), .o_last(o_last),
        .o_done(o_done), .o_ok(o_ok), .o_len(o_len), .o_src_ip(o_src_ip),
        .o_src_port(o_src_port), .o_good_cnt(o_good_cnt), .o_bad_cnt(o_bad_cnt),
        .o_drop_cnt(o_drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    logic [7:0] q[$], rx_q[$], pay[18];
    int sop_q[$], last_q[$];
    bit done_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (o_valid) begin
            if (o_sop) sop_q.push_back(rx_q.size());
            if (o_last) last_q.push_back(rx_q.size());
            rx_q.push_back(o_data);
        end
        if (o_done) done_q.push_back(o_ok);
    end

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
        for (int i = 0; i < 8; i++) c = (c[0] ^ d[i]) ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
        return c;
    endfunction

    task automatic build(input logic [47:0] dst, input logic [15:0] ulen);
        logic [7:0]  ip[20];
        logic [47:0] src;
        logic [31:0] s, c;
        logic [15:0] tot;
        tot = 16'd20 + ulen;
        src = 48'h020000000001;
        ip = '{8'h45, 8'h00, tot[15:8], tot[7:0], 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h11,
               8'h00, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h21, 8'h0A, 8'h00, 8'h00, 8'h02};
        s = 0;
        for (int i = 0; i < 20; i += 2) s += {16'd0, ip[i], ip[i+1]};
        s = s[15:0] + s[31:16];
        s = s[15:0] + s[31:16];
        ip[10] = ~s[15:8];
        ip[11] = ~s[7:0];
        q.delete();
        for (int i = 0; i < 6; i++) q.push_back(dst[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) q.push_back(src[47-8*i -: 8]);
        q.push_back(8'h08); q.push_back(8'h00);
        for (int i = 0; i < 20; i++) q.push_back(ip[i]);
        q.push_back(8'hC3); q.push_back(8'h50); q.push_back(8'hC3); q.push_back(8'h60);
        q.push_back(ulen[15:8]); q.push_back(ulen[7:0]); q.push_back(8'h00); q.push_back(8'h00);
        for (int i = 0; i < int'(ulen) - 8; i++) q.push_back(pay[i]);
        while (q.size() < 60) q.push_back(8'h00);
        c = '1;
        foreach (q[i]) c = crc_upd(c, q[i]);
        c = ~c;
        q.push_back(c[7:0]); q.push_back(c[15:8]); q.push_back(c[23:16]); q.push_back(c[31:24]);
    endtask

    // Sends npre 0x55 bytes, SFD, then the first n bytes of q; rst_n pulses low at byte rst_at.
    task automatic send(input int n, input int npre, input int rst_at, input int er_at);
        for (int p = 0; p <= npre; p++) begin
            @(negedge clk);
            i_dv = 1'b1; i_er = 1'b0; i_data = (p < npre) ? 8'h55 : 8'hD5;
        end
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            i_data = q[i]; i_er = (i == er_at); rst_n = (i != rst_at);
            if (i == rst_at) begin
                #1;
                check("rst_good", o_good_cnt, 0);
                check("rst_bad", o_bad_cnt, 0);
                check("rst_drop", o_drop_cnt, 0);
                check("rst_len", o_len, 0);
                check("rst_ip", o_src_ip, 0);
            end
        end
        @(negedge clk);
        i_dv = 1'b0; i_er = 1'b0; i_data = 8'd0; rst_n = 1'b1;
    endtask

    task automatic idle(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic clr();
        rx_q.delete(); sop_q.delete(); last_q.delete(); done_q.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        pay = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01,
                8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
        idle(3);
        check("reset_valid", o_valid, 0);
        check("reset_done", o_done, 0);
        check("reset_cnts", {o_good_cnt, o_bad_cnt, o_drop_cnt}, 0);
        check("reset_hdr", {o_len, o_src_port, o_src_ip}, 0);
        rst_n = 1'b1;
        idle(2);

        clr(); build(48'h0C54A5312485, 16'd26); send(q.size(), 7, -1, -1); idle(3);
        check("t1_nbytes", rx_q.size(), 18);
        for (int i = 0; i < 18 && i < rx_q.size(); i++) check("t1_byte", rx_q[i], pay[i]);
        check("t1_sop", sop_q.size() == 1 ? sop_q[0] : -1, 0);
        check("t1_last", last_q.size() == 1 ? last_q[0] : -1, 17);
        check("t1_ndone", done_q.size(), 1);
        check("t1_ok", done_q.size() > 0 ? done_q[0] : 1'b0, 1);
        check("t1_len", o_len, 18);
        check("t1_src_ip", o_src_ip, 32'h0A000021);
        check("t1_src_port", o_src_port, 16'hC350);
        check("t1_good", o_good_cnt, 1);

        clr(); build(48'h0C54A5312485, 16'd26); q[46] ^= 8'h01; send(q.size(), 7, -1, -1); idle(3);
        check("t2_nbytes", rx_q.size(), 18);
        check("t2_byte5", rx_q.size() > 4 ? rx_q[4] : 8'hFF, 8'h00);
        check("t2_ndone", done_q.size(), 1);
        check("t2_ok", done_q.size() > 0 ? done_q[0] : 1'b1, 0);
        check("t2_bad", o_bad_cnt, 1);
        check("t2_good", o_good_cnt, 1);

        clr();
        build(48'h0C54A5312485, 16'd26); q[37] = 8'h61; send(q.size(), 7, -1, -1); idle(3);
        build(48'h0C54A5312485, 16'd26); q[25] += 8'h01; send(q.size(), 7, -1, -1); idle(3);
        build(48'h0C54A5312485, 16'd26); q[5] = 8'h86; send(q.size(), 7, -1, -1); idle(3);
        check("t3_nbytes", rx_q.size(), 0);
        check("t3_ndone", done_q.size(), 0);
        check("t3_drop", o_drop_cnt, 3);

        clr(); build(48'hFFFFFFFFFFFF, 16'd8); send(q.size(), 7, -1, -1); idle(3);
        check("t4_nbytes", rx_q.size(), 0);
        check("t4_ndone", done_q.size(), 1);
        check("t4_ok", done_q.size() > 0 ? done_q[0] : 1'b0, 1);
        check("t4_len", o_len, 0);
        check("t4_good", o_good_cnt, 2);

        clr(); build(48'h0C54A5312485, 16'd26);
        send(52, 7, -1, -1);
        send(q.size(), 7, -1, -1); idle(3);
        check("t5_nbytes", rx_q.size(), 28);
        check("t5_sop2", sop_q.size() == 2 ? sop_q[1] : -1, 10);
        check("t5_last", last_q.size() == 1 ? last_q[0] : -1, 27);
        check("t5_ndone", done_q.size(), 2);
        check("t5_ok", done_q.size() == 2 ? {done_q[0], done_q[1]} : 2'b11, 2'b01);
        check("t5_bad", o_bad_cnt, 2);
        check("t5_good", o_good_cnt, 3);

        clr(); send(q.size(), 8, -1, -1); idle(3);
        check("longpre_nbytes", rx_q.size(), 0);
        check("longpre_ndone", done_q.size(), 0);
        check("longpre_drop", o_drop_cnt, 3);

        clr(); send(q.size(), 7, -1, 50); idle(3);
        check("er_nbytes", rx_q.size(), 18);
        check("er_ok", done_q.size() == 1 ? done_q[0] : 1'b1, 0);
        check("er_bad", o_bad_cnt, 3);

        send(q.size(), 7, 48, -1); idle(3);
        clr(); idle(1);
        check("t6_cnts", {o_good_cnt, o_bad_cnt, o_drop_cnt}, 0);
        send(q.size(), 7, -1, -1); idle(3);
        check("t6_nbytes", rx_q.size(), 18);
        check("t6_ndone", done_q.size(), 1);
        check("t6_ok", done_q.size() > 0 ? done_q[0] : 1'b0, 1);
        check("t6_good", o_good_cnt, 1);
        check("t6_bad", o_bad_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
